ppu_spr_eval: RTL and testbench
===============================

Name: ppu_spr_eval

Overview:
Per-scanline sprite evaluation stage of the PPU, in the PPU clock domain. It scans the 64-entry primary OAM through the 32-bit OAM read port and copies up to 8 sprites that cover the target scanline into the 8x32 secondary OAM. It then reports the sprite count, the sprite-overflow flag and whether sprite 0 is present. Its results are consumed by the render engine's sprite fetch, and the overflow flag feeds the PPUSTATUS logic.

Parameters:
N_OAM, 64, primary OAM entries (fixed; 6-bit address)
N_SEC, 8, secondary OAM entries (fixed; 3-bit address)

Ports:
i_clk  input  1  PPU clock
i_rstn  input  1  asynchronous active-low reset
i_start  input  1  begin evaluation; sampled only in IDLE
i_scanline  input  8  target scanline, 0..239
i_spr_h16  input  1  sprite height: 1 = 8x16, 0 = 8x8
o_oam_addr  output  6  primary OAM word address (registered)
i_oam_rdata  input  32  primary OAM word; [7:0]=Y, [15:8]=tile, [23:16]=attr, [31:24]=X; valid 1 cycle after address
o_oam2_addr  output  3  secondary OAM write address
o_oam2_wdata  output  32  secondary OAM write data
o_oam2_we  output  1  secondary OAM write enable
o_busy  output  1  high from the cycle after start accept until DONE, inclusive
o_done  output  1  1-cycle completion pulse
o_spr_cnt  output  4  sprites copied, 0..8
o_spr_ovfl  output  1  a 9th in-range sprite was found
o_spr0_in  output  1  OAM entry 0 was copied

Behaviour:
- Reset (async, i_rstn=0): state IDLE. All outputs are 0: o_oam_addr, o_oam2_*, o_busy, o_done, o_spr_cnt, o_spr_ovfl, o_spr0_in. A reset mid-operation aborts immediately; secondary OAM content is then undefined.
- Timing reference: cycle 0 is the edge at which i_start=1 is sampled in IDLE. At that edge the block latches i_scanline and i_spr_h16 and clears o_spr_cnt, o_spr_ovfl and o_spr0_in.
- State CLEAR, cycles 1..8: writes 0xFFFFFFFF to o_oam2_addr 0..7, one entry per cycle, with o_oam2_we=1.
- State SCAN, cycles 9..72: o_oam_addr = n during cycle 9+n, for n = 0..63.
- Evaluation stage: entry n's data is valid in cycle 10+n and is evaluated combinationally from i_oam_rdata.
  - In range when d = {1'b0,scanline} - {1'b0,Y} (9 bits) satisfies d[8]=0 and d[7:0] < (h16 ? 16 : 8).
  - There is no wrap: Y > scanline is always a miss.
- Write stage, registered, cycle 11+n, on a hit with cnt<8:
  - o_oam2_we=1, o_oam2_addr=cnt, o_oam2_wdata = the full 32-bit word; cnt increments in the same cycle.
  - If n=0, o_spr0_in=1 in that same cycle.
- Overflow: a hit with cnt=8 sets o_spr_ovfl=1 at cycle 11+n. The scan stops at once, state goes to DONE, and o_done=1 in that cycle. Once set, the flag holds until the next start.
- Normal end: the last write slot is cycle 74; DONE is cycle 75 with o_done=1. The block then returns to IDLE.
- o_spr_cnt, o_spr_ovfl and o_spr0_in stay stable from DONE until the next accepted start.
- Outside any write, o_oam2_we=0, and o_oam2_addr/o_oam2_wdata hold their last values.
- i_start while busy or in DONE is ignored. A start held high is re-accepted on the first IDLE cycle after DONE.
- Scanline and height are latched at start; later changes have no effect on the current pass.

Test Plan:
- All Y=0xFF, scanline=20, start -> 8 writes of 0xFFFFFFFF in cycles 1..8; no further writes; done at cycle 75; cnt=0, ovfl=0, spr0_in=0.
- Entries 3 and 7 with Y=5, h8, scanline=10, entry 3 word 0x40_01_22_05 -> oam2[0]=0x40012205 written in cycle 14, oam2[1]=entry 7 in cycle 18; done at 75; cnt=2, spr0_in=0.
- Entries 0..8 with Y=0, scanline=0 -> 8 writes in cycles 11..18; ovfl=1 and done in cycle 19; cnt=8, spr0_in=1; busy low from cycle 20.
- Entry 5 with Y=100: scanline 115 -> hit with h16=1, miss with h16=0. Y=0: scanline 7 h8 -> hit; scanline 8 -> miss. Y=0xF0, scanline 0 -> miss (no wrap).
- i_start pulse at cycle 30 of a pass -> ignored; the original pass completes with unchanged results. i_start held high -> second pass starts on the first IDLE cycle after cycle 75.
- i_rstn asserted at cycle 40 -> all outputs 0 immediately. A new start after release runs a full pass from CLEAR with correct results.

Source files
------------

// File: rtl/ppu_spr_eval.sv
// Per-scanline sprite evaluation: clears secondary OAM, scans 64 primary OAM
// entries and copies up to 8 in-range sprites, flagging overflow and sprite 0.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for i_start
// S_CLEAR | fill secondary OAM with 0xFFFFFFFF, one entry per cycle
// S_SCAN  | issue primary OAM addresses 0..63
// S_TAIL1 | last read in flight, entry 63 evaluated
// S_TAIL2 | last write slot
// S_DONE  | completion pulse, results stable
module ppu_spr_eval (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    input  logic [7:0]  i_scanline,
    input  logic        i_spr_h16,
    output logic [5:0]  o_oam_addr,
    input  logic [31:0] i_oam_rdata,
    output logic [2:0]  o_oam2_addr,
    output logic [31:0] o_oam2_wdata,
    output logic        o_oam2_we,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_spr_cnt,
    output logic        o_spr_ovfl,
    output logic        o_spr0_in
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_TAIL1,
        S_TAIL2,
        S_DONE
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [5:0]  r_oam_addr, w_oam_addr_nxt;
    logic        r_rd_vld, w_rd_vld_nxt;
    logic        r_rd_first, w_rd_first_nxt;
    logic [7:0]  r_line, w_line_nxt;
    logic        r_h16, w_h16_nxt;
    logic [2:0]  r_oam2_addr, w_oam2_addr_nxt;
    logic [31:0] r_oam2_wdata, w_oam2_wdata_nxt;
    logic        r_oam2_we, w_oam2_we_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic        r_ovfl, w_ovfl_nxt;
    logic        r_spr0, w_spr0_nxt;

    logic [8:0]  w_diff;
    logic        w_hit;

    // Nine-bit difference: a borrow means Y is below the line, so no wrap-around hits.
    assign w_diff = {1'b0, r_line} - {1'b0, i_oam_rdata[7:0]};
    assign w_hit  = !w_diff[8] && (r_h16 ? (w_diff[7:4] == 4'd0) : (w_diff[7:3] == 5'd0));

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_oam_addr   <= 6'd0;
            r_rd_vld     <= 1'b0;
            r_rd_first   <= 1'b0;
            r_line       <= 8'd0;
            r_h16        <= 1'b0;
            r_oam2_addr  <= 3'd0;
            r_oam2_wdata <= 32'd0;
            r_oam2_we    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cnt        <= 4'd0;
            r_ovfl       <= 1'b0;
            r_spr0       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_oam_addr   <= w_oam_addr_nxt;
            r_rd_vld     <= w_rd_vld_nxt;
            r_rd_first   <= w_rd_first_nxt;
            r_line       <= w_line_nxt;
            r_h16        <= w_h16_nxt;
            r_oam2_addr  <= w_oam2_addr_nxt;
            r_oam2_wdata <= w_oam2_wdata_nxt;
            r_oam2_we    <= w_oam2_we_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_cnt        <= w_cnt_nxt;
            r_ovfl       <= w_ovfl_nxt;
            r_spr0       <= w_spr0_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_oam_addr_nxt   = r_oam_addr;
        w_rd_vld_nxt     = 1'b0;
        w_rd_first_nxt   = 1'b0;
        w_line_nxt       = r_line;
        w_h16_nxt        = r_h16;
        w_oam2_addr_nxt  = r_oam2_addr;
        w_oam2_wdata_nxt = r_oam2_wdata;
        w_oam2_we_nxt    = 1'b0;
        w_busy_nxt       = r_busy;
        w_done_nxt       = 1'b0;
        w_cnt_nxt        = r_cnt;
        w_ovfl_nxt       = r_ovfl;
        w_spr0_nxt       = r_spr0;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt      = S_CLEAR;
                    w_line_nxt       = i_scanline;
                    w_h16_nxt        = i_spr_h16;
                    w_cnt_nxt        = 4'd0;
                    w_ovfl_nxt       = 1'b0;
                    w_spr0_nxt       = 1'b0;
                    w_busy_nxt       = 1'b1;
                    w_oam_addr_nxt   = 6'd0;
                    w_oam2_we_nxt    = 1'b1;
                    w_oam2_addr_nxt  = 3'd0;
                    w_oam2_wdata_nxt = 32'hFFFF_FFFF;
                end
            end
            S_CLEAR: begin
                if (r_oam2_addr == 3'd7) begin
                    w_state_nxt = S_SCAN;
                end else begin
                    w_oam2_we_nxt    = 1'b1;
                    w_oam2_addr_nxt  = r_oam2_addr + 3'd1;
                    w_oam2_wdata_nxt = 32'hFFFF_FFFF;
                end
            end
            S_SCAN: begin
                w_rd_vld_nxt   = 1'b1;
                w_rd_first_nxt = (r_oam_addr == 6'd0);
                if (r_oam_addr == 6'd63) begin
                    w_state_nxt = S_TAIL1;
                end else begin
                    w_oam_addr_nxt = r_oam_addr + 6'd1;
                end
            end
            S_TAIL1: w_state_nxt = S_TAIL2;
            S_TAIL2: begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Evaluation of the word returned for the previous cycle's address.
        if (r_rd_vld && w_hit) begin
            if (r_cnt[3]) begin
                w_ovfl_nxt     = 1'b1;
                w_state_nxt    = S_DONE;
                w_done_nxt     = 1'b1;
                w_rd_vld_nxt   = 1'b0;
                w_rd_first_nxt = 1'b0;
            end else begin
                w_oam2_we_nxt    = 1'b1;
                w_oam2_addr_nxt  = r_cnt[2:0];
                w_oam2_wdata_nxt = i_oam_rdata;
                w_cnt_nxt        = r_cnt + 4'd1;
                if (r_rd_first) begin
                    w_spr0_nxt = 1'b1;
                end
            end
        end
    end

    assign o_oam_addr   = r_oam_addr;
    assign o_oam2_addr  = r_oam2_addr;
    assign o_oam2_wdata = r_oam2_wdata;
    assign o_oam2_we    = r_oam2_we;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_spr_cnt    = r_cnt;
    assign o_spr_ovfl   = r_ovfl;
    assign o_spr0_in    = r_spr0;

endmodule

// File: tb/tb_ppu_spr_eval.sv
// Scoreboard bench for ppu_spr_eval: directed OAM contents with hand-computed
// secondary OAM writes and completion results queued per pass.
module tb_ppu_spr_eval;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  line = 8'd0;
    logic        h16 = 1'b0;
    logic [5:0]  oam_addr;
    logic [31:0] rdata = 32'd0;
    logic [2:0]  oam2_addr;
    logic [31:0] oam2_wdata;
    logic        oam2_we;
    logic        busy;
    logic        done;
    logic [3:0]  spr_cnt;
    logic        spr_ovfl;
    logic        spr0_in;

    ppu_spr_eval dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_scanline   (line),
        .i_spr_h16    (h16),
        .o_oam_addr   (oam_addr),
        .i_oam_rdata  (rdata),
        .o_oam2_addr  (oam2_addr),
        .o_oam2_wdata (oam2_wdata),
        .o_oam2_we    (oam2_we),
        .o_busy       (busy),
        .o_done       (done),
        .o_spr_cnt    (spr_cnt),
        .o_spr_ovfl   (spr_ovfl),
        .o_spr0_in    (spr0_in)
    );

    always #5 clk = ~clk;

    logic [31:0] oam [64];
    always @(posedge clk) rdata <= oam[oam_addr];

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {int e; logic [2:0] a; logic [31:0] d;} wr_t;
    typedef struct {int e; logic [3:0] cnt; logic ov; logic s0;} dn_t;
    wr_t wq[$];
    dn_t dq[$];

    int n_chk = 0;
    int n_fail = 0;
    bit busy_low_chk = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    // Monitor: every write and every done pulse must match the head of its queue.
    always @(negedge clk) begin
        wr_t w;
        dn_t d;
        if (busy_low_chk) begin
            check("busy_after_done", {31'd0, busy}, 32'd0);
            busy_low_chk = 1'b0;
        end
        if (oam2_we) begin
            if (wq.size() == 0) begin
                check("unexpected_write_addr", {29'd0, oam2_addr}, 32'hFFFF_FFFF);
            end else begin
                w = wq.pop_front();
                check("write_edge", edge_cnt, w.e);
                check("write_addr", {29'd0, oam2_addr}, {29'd0, w.a});
                check("write_data", oam2_wdata, w.d);
            end
        end
        if (done) begin
            if (dq.size() == 0) begin
                check("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                d = dq.pop_front();
                check("done_edge", edge_cnt, d.e);
                check("done_cnt", {28'd0, spr_cnt}, {28'd0, d.cnt});
                check("done_ovfl", {31'd0, spr_ovfl}, {31'd0, d.ov});
                check("done_spr0", {31'd0, spr0_in}, {31'd0, d.s0});
                check("done_busy", {31'd0, busy}, 32'd1);
            end
            busy_low_chk = 1'b1;
        end
    end

    task automatic push_clear(input int t0);
        wr_t w;
        for (int k = 0; k < 8; k++) begin
            w.e = t0 + k;
            w.a = k[2:0];
            w.d = 32'hFFFF_FFFF;
            wq.push_back(w);
        end
    endtask

    task automatic push_wr(input int t0, input int cyc, input logic [2:0] a, input logic [31:0] dat);
        wr_t w;
        w.e = t0 + cyc - 1;
        w.a = a;
        w.d = dat;
        wq.push_back(w);
    endtask

    task automatic push_done(input int t0, input int cyc, input logic [3:0] c, input logic ov, input logic s0);
        dn_t d;
        d.e   = t0 + cyc - 1;
        d.cnt = c;
        d.ov  = ov;
        d.s0  = s0;
        dq.push_back(d);
    endtask

    task automatic arm(input logic [7:0] sl, input logic hh, output int t0);
        @(negedge clk);
        line  = sl;
        h16   = hh;
        start = 1'b1;
        t0    = edge_cnt + 1;
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while ((wq.size() != 0 || dq.size() != 0) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check({nm, "_timeout"}, {31'd0, (i >= 400)}, 32'd0);
        wq.delete();
        dq.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic fill_ff();
        for (int i = 0; i < 64; i++) oam[i] = 32'hFFFF_FFFF;
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_oam_addr"}, {26'd0, oam_addr}, 32'd0);
        check({nm, "_oam2_addr"}, {29'd0, oam2_addr}, 32'd0);
        check({nm, "_oam2_wdata"}, oam2_wdata, 32'd0);
        check({nm, "_oam2_we"}, {31'd0, oam2_we}, 32'd0);
        check({nm, "_busy"}, {31'd0, busy}, 32'd0);
        check({nm, "_done"}, {31'd0, done}, 32'd0);
        check({nm, "_cnt"}, {28'd0, spr_cnt}, 32'd0);
        check({nm, "_ovfl"}, {31'd0, spr_ovfl}, 32'd0);
        check({nm, "_spr0"}, {31'd0, spr0_in}, 32'd0);
    endtask

    // Single-candidate pass: only entry 5 may hit, write would land in cycle 16.
    task automatic run_e5(input string nm, input logic [7:0] sl, input logic hh, input logic hit);
        int t0;
        arm(sl, hh, t0);
        push_clear(t0);
        if (hit) push_wr(t0, 16, 3'd0, oam[5]);
        push_done(t0, 75, hit ? 4'd1 : 4'd0, 1'b0, 1'b0);
        release_start();
        wait_idle(nm);
    endtask

    task automatic setup_two();
        fill_ff();
        oam[3] = 32'h4001_2205;
        oam[7] = 32'h1122_3305;
    endtask

    task automatic push_two(input int t0);
        push_clear(t0);
        push_wr(t0, 14, 3'd0, 32'h4001_2205);
        push_wr(t0, 18, 3'd1, 32'h1122_3305);
        push_done(t0, 75, 4'd2, 1'b0, 1'b0);
    endtask

    initial begin
        int t0;
        fill_ff();
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;

        // No sprite in range: only the clear writes.
        arm(8'd20, 1'b0, t0);
        push_clear(t0);
        push_done(t0, 75, 4'd0, 1'b0, 1'b0);
        release_start();
        wait_idle("empty");

        // Two hits at entries 3 and 7.
        setup_two();
        arm(8'd10, 1'b0, t0);
        push_two(t0);
        release_start();
        wait_idle("two");

        // Nine hits from entry 0: eight copies then overflow at cycle 19.
        fill_ff();
        for (int n = 0; n < 9; n++) oam[n] = {8'h20 + 8'(n), 8'h03, 8'(n), 8'h00};
        arm(8'd0, 1'b0, t0);
        push_clear(t0);
        for (int n = 0; n < 8; n++) push_wr(t0, 11 + n, 3'(n), {8'h20 + 8'(n), 8'h03, 8'(n), 8'h00});
        push_done(t0, 19, 4'd8, 1'b1, 1'b1);
        release_start();
        wait_idle("ovfl");

        // Height and range boundaries on entry 5.
        fill_ff();
        oam[5] = 32'h0A0B_0C64;
        run_e5("h16_d15", 8'd115, 1'b1, 1'b1);
        run_e5("h8_d15", 8'd115, 1'b0, 1'b0);
        oam[5] = 32'h0A0B_0C00;
        run_e5("h8_d7", 8'd7, 1'b0, 1'b1);
        run_e5("h8_d8", 8'd8, 1'b0, 1'b0);
        oam[5] = 32'h0A0B_0CF0;
        run_e5("nowrap", 8'd0, 1'b1, 1'b0);

        // Start pulse and input changes mid-pass are ignored.
        setup_two();
        arm(8'd10, 1'b0, t0);
        push_two(t0);
        release_start();
        while (edge_cnt < t0 + 29) @(negedge clk);
        start = 1'b1;
        line  = 8'd200;
        h16   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignored_start");

        // Start held high: second pass accepted on the IDLE cycle after done.
        arm(8'd10, 1'b0, t0);
        push_two(t0);
        push_two(t0 + 76);
        while (edge_cnt < t0 + 76) @(negedge clk);
        start = 1'b0;
        wait_idle("held_start");

        // Reset in the middle of a pass, then a clean pass.
        fill_ff();
        arm(8'd20, 1'b0, t0);
        push_clear(t0);
        push_done(t0, 75, 4'd0, 1'b0, 1'b0);
        release_start();
        while (edge_cnt < t0 + 39) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check_zero("midreset");
        wq.delete();
        dq.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        setup_two();
        arm(8'd10, 1'b0, t0);
        push_two(t0);
        release_start();
        wait_idle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
